// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Widths, MMIO register offsets, load/store size codes, UART states.
package data_mem_responder_pkg;

    localparam int XLEN = 32;
    localparam int ALEN = 32;

    localparam logic [1:0] MMIO_LED_OFS  = 2'd0;
    localparam logic [1:0] MMIO_UART_OFS = 2'd1;
    localparam logic [1:0] MMIO_STAT_OFS = 2'd2;

    localparam logic [2:0] F3_BYTE   = 3'b000;
    localparam logic [2:0] F3_HALF   = 3'b001;
    localparam logic [2:0] F3_WORD   = 3'b010;
    localparam logic [2:0] F3_BYTE_U = 3'b100;
    localparam logic [2:0] F3_HALF_U = 3'b101;

    typedef enum logic [1:0] {
        U_IDLE  = 2'd0,
        U_START = 2'd1,
        U_DATA  = 2'd2,
        U_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/data_mem_responder_uart.sv
// 8N1 UART transmit serializer, LSB first.
// busy stays high from the accept edge until the STOP bit has completed.
module uart_tx_serializer
    import data_mem_responder_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    uart_state_t   r_state;
    uart_state_t   w_state_n;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_n;
    logic [2:0]    r_bit;
    logic [2:0]    w_bit_n;
    logic [7:0]    r_sh;
    logic [7:0]    w_sh_n;
    logic          w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= U_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_sh    <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_bit   <= w_bit_n;
            r_sh    <= w_sh_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_bit_n   = r_bit;
        w_sh_n    = r_sh;
        w_last    = (r_cnt == CW'(CLKS_PER_BIT - 1));
        tx        = 1'b1;
        unique case (r_state)
            U_IDLE: begin
                if (start) begin
                    w_state_n = U_START;
                    w_cnt_n   = '0;
                    w_bit_n   = '0;
                    w_sh_n    = data;
                end
            end
            U_START: begin
                tx = 1'b0;
                w_cnt_n = w_last ? '0 : r_cnt + 1'b1;
                if (w_last) w_state_n = U_DATA;
            end
            U_DATA: begin
                tx = r_sh[0];
                w_cnt_n = w_last ? '0 : r_cnt + 1'b1;
                if (w_last) begin
                    w_sh_n  = {1'b0, r_sh[7:1]};
                    w_bit_n = r_bit + 1'b1;
                    if (r_bit == 3'd7) w_state_n = U_STOP;
                end
            end
            U_STOP: begin
                w_cnt_n = w_last ? '0 : r_cnt + 1'b1;
                if (w_last) w_state_n = U_IDLE;
            end
            default: w_state_n = U_IDLE;
        endcase
    end

    assign busy = (r_state != U_IDLE);

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: BRAM store, LED and UART-TX MMIO, load extension.
// UART serializer and STATUS register exist only when DMEM_UART_EN is defined.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS  = 4096,
    parameter              INIT_FILE    = "",
    parameter logic [31:0] MMIO_BASE    = 32'h8000_0000,
    parameter int          LED_W        = 8,
    parameter int          CLKS_PER_BIT = 868
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ALEN-1:0]  dmem_addr,
    input  logic [XLEN-1:0]  dmem_wdata,
    input  logic             dmem_we,
    input  logic [3:0]       dmem_be,
    input  logic [2:0]       dmem_funct3,
    output logic [XLEN-1:0]  dmem_rdata,
    output logic [LED_W-1:0] leds_out,
    output logic             uart_tx
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic          w_mmio;
    logic [AW-1:0] w_idx;
    logic [1:0]    w_reg;
    logic [31:0]   w_wdata;
    logic [31:0]   w_mask;
    logic [31:0]   w_status;
    logic          w_tx;

    assign w_mmio = (dmem_addr[31:28] == MMIO_BASE[31:28]);
    assign w_idx  = dmem_addr[AW+1:2];
    assign w_reg  = dmem_addr[3:2];

    always_comb begin
        unique case (dmem_funct3[1:0])
            2'b00:   w_wdata = {4{dmem_wdata[7:0]}};
            2'b01:   w_wdata = {2{dmem_wdata[15:0]}};
            default: w_wdata = dmem_wdata;
        endcase
        for (int i = 0; i < 4; i++) w_mask[8*i +: 8] = {8{dmem_be[i]}};
    end

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_ram_q;

    // Read-first: the registered word is the value before this edge's store.
    always_ff @(posedge clk) begin
        if (dmem_we && !w_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (dmem_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
        r_ram_q <= r_mem[w_idx];
    end

    logic [LED_W-1:0] r_leds;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_leds <= '0;
        end else if (dmem_we && w_mmio && w_reg == MMIO_LED_OFS) begin
            r_leds <= (r_leds & ~w_mask[LED_W-1:0])
                    | (w_wdata[LED_W-1:0] & w_mask[LED_W-1:0]);
        end
    end

`ifdef DMEM_UART_EN
    logic w_tx_wr;
    logic w_st_wr;
    logic w_busy;
    logic r_ovf;

    assign w_tx_wr = dmem_we && w_mmio && (w_reg == MMIO_UART_OFS);
    assign w_st_wr = dmem_we && w_mmio && (w_reg == MMIO_STAT_OFS);

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk  (clk),
        .rst_n(rst_n),
        .start(w_tx_wr && !w_busy),
        .data (w_wdata[7:0]),
        .busy (w_busy),
        .tx   (w_tx)
    );

    // A dropped byte outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ovf <= 1'b0;
        else if (w_tx_wr && w_busy) r_ovf <= 1'b1;
        else if (w_st_wr) r_ovf <= 1'b0;
    end

    assign w_status = {30'b0, r_ovf, w_busy};
`else
    logic w_unused_cfg;
    assign w_unused_cfg = CLKS_PER_BIT[0];
    assign w_status = '0;
    assign w_tx     = 1'b1;
`endif

    logic [31:0] r_mmio_q;
    logic        r_is_mmio;
    logic [2:0]  r_f3;
    logic [1:0]  r_ofs;
    logic        r_live;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mmio_q  <= '0;
            r_is_mmio <= 1'b0;
            r_f3      <= '0;
            r_ofs     <= '0;
            r_live    <= 1'b0;
        end else begin
            r_is_mmio <= w_mmio;
            r_f3      <= dmem_funct3;
            r_ofs     <= dmem_addr[1:0];
            r_live    <= 1'b1;
            unique case (w_reg)
                MMIO_LED_OFS:  r_mmio_q <= 32'(r_leds);
                MMIO_STAT_OFS: r_mmio_q <= w_status;
                default:       r_mmio_q <= '0;
            endcase
        end
    end

    logic [31:0] w_raw;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sx;
    logic [31:0] w_ext;

    always_comb begin
        w_raw  = r_is_mmio ? r_mmio_q : r_ram_q;
        w_byte = w_raw[8*r_ofs +: 8];
        w_half = r_ofs[1] ? w_raw[31:16] : w_raw[15:0];
        w_sx   = ~r_f3[2];
        unique case (r_f3[1:0])
            2'b00:   w_ext = {{24{w_sx & w_byte[7]}}, w_byte};
            2'b01:   w_ext = {{16{w_sx & w_half[15]}}, w_half};
            default: w_ext = w_raw;
        endcase
    end

    logic w_unused;
    assign w_unused = &{1'b0, dmem_addr};

    assign dmem_rdata = r_live ? w_ext : '0;
    assign leds_out   = r_leds;
    assign uart_tx    = w_tx;

endmodule
